// File: rtl/pipeline_control.sv
// Pipeline sequencer: drives load enables and flushes for IF/ID, ID/EX, EX/MEM, MEM/WB
// and the PC. Handles load-use stalls, branch flushes, memory freezes, drain and halt.
module pipeline_control #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        idExMemRead,
  input  logic [4:0]  idExRt,
  input  logic [4:0]  ifIdRs,
  input  logic [4:0]  ifIdRt,
  input  logic        ifIdUsesRt,
  input  logic        branchTaken,
  input  logic        memReq,
  input  logic        memReady,
  input  logic        haltReq,
  input  logic        resume,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExWrite,
  output logic        idExFlush,
  output logic        exMemWrite,
  output logic        memWbFlush,
  output logic        halted,
  output logic        memTimeout,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_LAST  = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state_reg, state_next;
  logic        ret_drain_reg, ret_drain_next;
  logic [3:0]  drain_cnt_reg, drain_cnt_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        timeout_reg, timeout_next;
  logic        halted_reg;
  logic [15:0] stall_cnt_reg;

  logic freeze, load_use, in_drain;
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c;
  logic id_ex_flush_c, ex_mem_write_c, mem_wb_flush_c;

  assign freeze   = memReq && !memReady && (state_reg != HALTED);
  assign load_use = idExMemRead && (idExRt != 5'd0) &&
                    ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));
  // A MEM_WAIT entered from DRAIN keeps draining once the access completes
  assign in_drain = (state_reg == DRAIN) || ((state_reg == MEM_WAIT) && ret_drain_reg);

  always_comb begin
    state_next     = state_reg;
    ret_drain_next = ret_drain_reg;
    drain_cnt_next = drain_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    timeout_next   = timeout_reg;
    pc_write_c     = 1'b0;
    if_id_write_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_write_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_write_c = 1'b0;
    mem_wb_flush_c = 1'b0;

    if (state_reg == HALTED) begin
      if (resume) state_next = RUN;
    end else if (freeze) begin
      mem_wb_flush_c = 1'b1;
      if (wait_cnt_reg != 8'hFF) wait_cnt_next = wait_cnt_reg + 8'd1;
      if (wait_cnt_next >= TIMEOUT_CNT) timeout_next = 1'b1;
      if (state_reg == RUN) begin
        state_next     = MEM_WAIT;
        ret_drain_next = 1'b0;
      end
    end else begin
      wait_cnt_next  = 8'd0;
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      id_ex_write_c  = 1'b1;
      ex_mem_write_c = 1'b1;
      if (branchTaken) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        pc_write_c    = !in_drain;
      end else if (load_use || in_drain) begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        id_ex_flush_c = 1'b1;
      end

      if (in_drain) begin
        drain_cnt_next = drain_cnt_reg + 4'd1;
        state_next     = (drain_cnt_reg == DRAIN_LAST) ? HALTED : DRAIN;
      end else if (haltReq) begin
        drain_cnt_next = 4'd0;
        state_next     = DRAIN;
      end else begin
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= RUN;
      ret_drain_reg <= 1'b0;
      drain_cnt_reg <= 4'd0;
      wait_cnt_reg  <= 8'd0;
      timeout_reg   <= 1'b0;
      halted_reg    <= 1'b0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      ret_drain_reg <= ret_drain_next;
      drain_cnt_reg <= drain_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      halted_reg    <= (state_next == HALTED);
      if ((state_reg != HALTED) && !pc_write_c && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  // Strobes are forced inactive for as long as reset is held
  assign pcWrite    = pc_write_c     && resetN;
  assign ifIdWrite  = if_id_write_c  && resetN;
  assign ifIdFlush  = if_id_flush_c  && resetN;
  assign idExWrite  = id_ex_write_c  && resetN;
  assign idExFlush  = id_ex_flush_c  && resetN;
  assign exMemWrite = ex_mem_write_c && resetN;
  assign memWbFlush = mem_wb_flush_c && resetN;
  assign halted     = halted_reg;
  assign memTimeout = timeout_reg;
  assign stallCount = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_control;

  logic        clock = 1'b0;
  logic        resetN;
  logic        idExMemRead, ifIdUsesRt, branchTaken, memReq, memReady, haltReq, resume;
  logic [4:0]  idExRt, ifIdRs, ifIdRt;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush;
  logic        halted, memTimeout;
  logic [15:0] stallCount;

  typedef struct packed {
    logic [6:0]  str;
    logic        h;
    logic        to;
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests  = 0;
  int    failed = 0;

  // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush}
  localparam logic [6:0] S_DEF = 7'b1101010;
  localparam logic [6:0] S_FRZ = 7'b0000001;
  localparam logic [6:0] S_BR  = 7'b1111110;
  localparam logic [6:0] S_LU  = 7'b0001110;
  localparam logic [6:0] S_BRD = 7'b0111110;
  localparam logic [6:0] S_OFF = 7'b0000000;

  always #5 clock = ~clock;

  pipeline_control #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(64)) dut (
    .clock(clock), .resetN(resetN),
    .idExMemRead(idExMemRead), .idExRt(idExRt), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
    .ifIdUsesRt(ifIdUsesRt), .branchTaken(branchTaken), .memReq(memReq),
    .memReady(memReady), .haltReq(haltReq), .resume(resume),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
    .memWbFlush(memWbFlush), .halted(halted), .memTimeout(memTimeout),
    .stallCount(stallCount)
  );

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush,
           halted, memTimeout, stallCount};
      tests++;
      if (a !== e) begin
        failed++;
        $display("[TB] FAIL %s: got str=%b halted=%b to=%b sc=%0d, expected str=%b halted=%b to=%b sc=%0d",
                 n, a.str, a.h, a.to, a.sc, e.str, e.h, e.to, e.sc);
      end else begin
        $display("[TB] ok %s: str=%b halted=%b to=%b sc=%0d", n, a.str, a.h, a.to, a.sc);
      end
    end
  end

  task automatic idle();
    idExMemRead = 1'b0; idExRt = 5'd0; ifIdRs = 5'd0; ifIdRt = 5'd0; ifIdUsesRt = 1'b0;
    branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0; haltReq = 1'b0; resume = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [6:0] s, input logic h, input logic to,
                     input logic [15:0] sc);
    exp_q.push_back({s, h, to, sc});
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    idle();
    @(posedge clock);
    #1;
    cyc("reset_held", S_OFF, 0, 0, 16'd0);

    // Reset in the middle of a memory wait
    resetN = 1'b1;
    cyc("run_default", S_DEF, 0, 0, 16'd0);
    memReq = 1'b1;
    for (int i = 0; i < 5; i++) cyc("pre_reset_freeze", S_FRZ, 0, 0, 16'(i));
    idle(); resetN = 1'b0;
    cyc("mid_wait_reset", S_OFF, 0, 0, 16'd0);
    resetN = 1'b1;
    cyc("after_reset_default", S_DEF, 0, 0, 16'd0);

    // Load-use hazards
    idExMemRead = 1'b1; idExRt = 5'd8; ifIdRs = 5'd8;
    cyc("loaduse_rs", S_LU, 0, 0, 16'd0);
    idle();
    cyc("loaduse_bubble", S_DEF, 0, 0, 16'd1);
    idExMemRead = 1'b1; idExRt = 5'd0; ifIdRs = 5'd0;
    cyc("loaduse_r0", S_DEF, 0, 0, 16'd1);
    idle(); idExMemRead = 1'b1; idExRt = 5'd9; ifIdRs = 5'd3; ifIdRt = 5'd9; ifIdUsesRt = 1'b1;
    cyc("loaduse_rt", S_LU, 0, 0, 16'd1);
    idle();
    cyc("loaduse_rt_after", S_DEF, 0, 0, 16'd2);
    idExMemRead = 1'b1; idExRt = 5'd9; ifIdRs = 5'd3; ifIdRt = 5'd9; ifIdUsesRt = 1'b0;
    cyc("loaduse_rt_unused", S_DEF, 0, 0, 16'd2);

    // Branch wins over load-use
    idle(); branchTaken = 1'b1; idExMemRead = 1'b1; idExRt = 5'd8; ifIdRs = 5'd8;
    cyc("branch_over_loaduse", S_BR, 0, 0, 16'd2);
    idle();
    cyc("branch_after", S_DEF, 0, 0, 16'd2);

    // Short memory wait, branch ignored while frozen
    memReq = 1'b1;
    cyc("memwait_1", S_FRZ, 0, 0, 16'd2);
    branchTaken = 1'b1;
    cyc("memwait_2_branch", S_FRZ, 0, 0, 16'd3);
    branchTaken = 1'b0;
    cyc("memwait_3", S_FRZ, 0, 0, 16'd4);
    memReady = 1'b1;
    cyc("memwait_release", S_DEF, 0, 0, 16'd5);
    idle();
    cyc("memwait_after", S_DEF, 0, 0, 16'd5);

    // Timeout after 64 consecutive wait cycles
    memReq = 1'b1;
    for (int i = 0; i < 64; i++) cyc("timeout_wait", S_FRZ, 0, 0, 16'(5 + i));
    memReady = 1'b1;
    cyc("timeout_set", S_DEF, 0, 1, 16'd69);
    idle();
    cyc("timeout_sticky", S_DEF, 0, 1, 16'd69);

    // Halt with a freeze in the middle of the drain
    haltReq = 1'b1;
    cyc("halt_req_normal", S_DEF, 0, 1, 16'd69);
    cyc("drain_1", S_LU, 0, 1, 16'd69);
    memReq = 1'b1;
    cyc("drain_freeze_1", S_FRZ, 0, 1, 16'd70);
    cyc("drain_freeze_2", S_FRZ, 0, 1, 16'd71);
    memReq = 1'b0;
    cyc("drain_2", S_LU, 0, 1, 16'd72);
    cyc("drain_3", S_LU, 0, 1, 16'd73);
    cyc("halted_1", S_OFF, 1, 1, 16'd74);
    cyc("halted_2", S_OFF, 1, 1, 16'd74);
    haltReq = 1'b0; resume = 1'b1;
    cyc("resume_cycle", S_OFF, 1, 1, 16'd74);
    resume = 1'b0;
    cyc("resumed_run", S_DEF, 0, 1, 16'd74);

    // Branch in the first drain cycle
    haltReq = 1'b1;
    cyc("halt_req_2", S_DEF, 0, 1, 16'd74);
    haltReq = 1'b0; branchTaken = 1'b1;
    cyc("drain_branch", S_BRD, 0, 1, 16'd74);
    branchTaken = 1'b0;
    cyc("drain_b2", S_LU, 0, 1, 16'd75);
    cyc("drain_b3", S_LU, 0, 1, 16'd76);
    cyc("halted_b", S_OFF, 1, 1, 16'd77);
    resume = 1'b1;
    cyc("resume_b", S_OFF, 1, 1, 16'd77);
    resume = 1'b0;
    cyc("resumed_b", S_DEF, 0, 1, 16'd77);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It detects load-use hazards, flushes on taken branches, freezes the pipe during data-memory wait states, and drains and halts the pipe on request. It sits beside the ID stage and drives write-enable and flush strobes into every pipeline register. It also keeps a saturating stall counter and a memory-timeout flag.

Parameters:
DRAIN_CYCLES, 3, number of cycles of bubble insertion in DRAIN before HALTED; must be 1..15.
MEM_TIMEOUT, 64, number of consecutive wait cycles before memTimeout sets; must be 1..255.

Ports:
clock  in  1  pipeline clock, rising edge.
resetN  in  1  asynchronous, active-low reset.
idExMemRead  in  1  instruction in ID/EX is a load.
idExRt  in  5  rt field held in ID/EX.
ifIdRs  in  5  rs field of the instruction in IF/ID.
ifIdRt  in  5  rt field of the instruction in IF/ID.
ifIdUsesRt  in  1  instruction in IF/ID reads rt as a source.
branchTaken  in  1  branch resolved taken in EX this cycle.
memReq  in  1  MEM stage is accessing data memory.
memReady  in  1  data memory completes the access this cycle.
haltReq  in  1  level request to drain and halt.
resume  in  1  one-cycle pulse that leaves HALTED.
pcWrite  out  1  PC load enable.
ifIdWrite  out  1  IF/ID load enable.
ifIdFlush  out  1  IF/ID clears to NOP on this edge.
idExWrite  out  1  ID/EX load enable.
idExFlush  out  1  ID/EX loads a bubble, with all control fields 0.
exMemWrite  out  1  EX/MEM load enable.
memWbFlush  out  1  MEM/WB loads a bubble.
halted  out  1  pipe is empty and stopped.
memTimeout  out  1  sticky error flag.
stallCount  out  16  saturating count of cycles with pcWrite=0 while in RUN, DRAIN or MEM_WAIT.

Behaviour:
- Strobe outputs are Mealy: combinational from the state and the current inputs. Counters, state, halted and memTimeout are registered.
- Reset (resetN=0, asynchronous):
  - state=RUN; all counters=0; halted=0; memTimeout=0.
  - While reset is held, all write enables are 0 and all flushes are 0.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Default strobe values in RUN: all write enables 1, all flushes 0.
- Priority within RUN, DRAIN and MEM_WAIT: mem freeze > branch flush > load-use stall > drain.
- Mem freeze (memReq=1 and memReady=0, any of the three states):
  - pcWrite, ifIdWrite, idExWrite and exMemWrite are 0; memWbFlush=1.
  - The other flushes are 0, and branchTaken is ignored that cycle. The branch stays in EX and is re-seen after release.
  - RUN goes to MEM_WAIT. DRAIN holds state and its drain counter.
  - The wait counter increments and saturates. When it reaches MEM_TIMEOUT, memTimeout sets and stays set until reset. Waiting continues.
- MEM_WAIT exit: memReady=1 gives default strobes for that cycle (the access completes), the wait counter clears, and the state returns to the one it came from (RUN or DRAIN; a 1-bit return flag is stored).
- Branch flush (branchTaken=1, no freeze): ifIdFlush=1 and idExFlush=1. pcWrite=1 except in DRAIN.
- Load-use stall: condition is idExMemRead=1 and idExRt≠0 and (idExRt==ifIdRs or (ifIdUsesRt and idExRt==ifIdRt)).
  - Response: pcWrite=0, ifIdWrite=0, idExFlush=1.
  - Lasts exactly 1 cycle, because the bubble clears idExMemRead on the next cycle.
- Drain:
  - haltReq=1 in RUN with no freeze: that cycle is normal; the state goes to DRAIN on the next edge and the drain counter goes to 0.
  - In DRAIN: pcWrite=0, ifIdWrite=0, idExFlush=1, later stages advance.
  - The drain counter increments on each non-frozen cycle. At DRAIN_CYCLES the state goes to HALTED.
- HALTED:
  - halted=1; all write enables 0; flushes 0.
  - resume=1 goes to RUN on the next edge and halted=0. haltReq is ignored in HALTED.
- stallCount: +1 on each cycle with pcWrite=0 in RUN, MEM_WAIT or DRAIN. It saturates at 0xFFFF and is not counted in HALTED.
- Register 0 never triggers a load-use stall.

Test Plan:
- Reset mid-MEM_WAIT: assert memReq=1, memReady=0 for 5 cycles, pulse resetN low, hold memReq/memReady low → state RUN, strobes at defaults, stallCount=0, memTimeout=0.
- Load-use: lw with idExRt=8, next instruction ifIdRs=8 → exactly 1 cycle of pcWrite=0, ifIdWrite=0, idExFlush=1, then defaults; stallCount=1. Repeat with idExRt=0 → no stall.
- Branch and load-use in the same cycle: branchTaken=1 with a load-use match → ifIdFlush=1, idExFlush=1, pcWrite=1; no stall.
- Memory wait: memReq=1 with memReady low for 3 cycles, then high → freeze strobes plus memWbFlush=1 for 3 cycles, defaults on the 4th; stallCount=3. Hold memReady low for 64 cycles → memTimeout=1, sticky.
- Halt with mid-drain freeze: haltReq in RUN → DRAIN; a 2-cycle freeze inside DRAIN delays halted. With DRAIN_CYCLES=3, halted=1 after 3 non-frozen drain cycles; resume pulse → RUN one cycle later.
- Branch during DRAIN: branchTaken=1 in the first DRAIN cycle → ifIdFlush=1, idExFlush=1, pcWrite=0; drain count unaffected.
